// File: rtl/ram_byte_master_pkg.sv
// Shared codes for the byte RAM master: En[20:17] operation codes, request
// encoding, sequencer states and the virtual-to-pseudo address mapping.
package ram_byte_master_pkg;

    typedef enum logic [3:0] {
        EN_PAGE = 4'b0000,
        EN_ZPCY = 4'b0010,
        EN_ZPY  = 4'b0100,
        EN_CA1  = 4'b0110,
        EN_ZPX  = 4'b1000,
        EN_CA3  = 4'b1010,
        EN_ZPCX = 4'b1100,
        EN_CC   = 4'b1110,
        EN_NOP  = 4'b1111
    } en_code_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_PAGE  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_ADDR,
        ST_WR_HI,
        ST_WR_LO,
        ST_PAGE
    } state_t;

    // High address byte goes out inverted on either the A1/A2 or the A3/A4 pair.
    function automatic logic [15:0] addr_map(input logic [15:0] addr, input logic ca1);
        logic [7:0] pair;
        pair = {~addr[11:8], ~addr[15:12]};
        return ca1 ? {8'hFF, pair} : {pair, 8'hFF};
    endfunction

endpackage

// File: rtl/ram_byte_master_tn_edge.sv
// Phase-strobe edge detector: one registered copy of tn, edges suppressed on
// the first clock after reset so a strobe already low is not seen as a fall.
module tn_edge (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [10:1] i_tn,
    output logic        o_t4_rise,
    output logic        o_t5_fall,
    output logic        o_t7_fall
);

    logic [10:1] r_tn;
    logic        r_armed;
    logic        w_unused_tn;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tn    <= '1;
            r_armed <= 1'b0;
        end else begin
            r_tn    <= i_tn;
            r_armed <= 1'b1;
        end
    end

    assign o_t4_rise = r_armed & ~r_tn[4] &  i_tn[4];
    assign o_t5_fall = r_armed &  r_tn[5] & ~i_tn[5];
    assign o_t7_fall = r_armed &  r_tn[7] & ~i_tn[7];

    assign w_unused_tn = ^{r_tn[10:8], r_tn[6], r_tn[3:1]};

endmodule

// File: rtl/ram_byte_master.sv
// Byte-wide RAM access sequencer: turns read/write/page-load requests into
// En[20:17]/En[28:25] codes and address/data nibbles, paced by the tn strobes.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | ready; accept on tn5 fall, drive address
// ST_ARM   | tn7 fall: CA1/CA3 code, high write nibble on Data
// ST_ADDR  | read: capture {Y,X} after tn4 rise; tn7 fall dispatches op
// ST_WR_HI | ZPY active; tn7 fall: low nibble, ZPX
// ST_WR_LO | ZPX active; tn7 fall: done
// ST_PAGE  | page code + 10w active; tn7 fall: done
module ram_byte_master
    import ram_byte_master_pkg::*;
#(
    parameter logic [3:0] IDLE_OP  = 4'b1111,
    parameter logic [3:0] PAGE_10W = 4'b0111
) (
    input  logic        ram_clk,
    input  logic        initn,
    input  logic [10:1] tn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic        req_ca1,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [15:0] Addr_n,
    output logic [3:0]  Z2,
    output logic [3:0]  Z3,
    output logic [3:0]  Data,
    output logic [3:0]  en_ram,
    output logic [3:0]  en_10w,
    input  logic [3:0]  X,
    input  logic [3:0]  Y
);

    logic        w_t4_rise;
    logic        w_t5_fall;
    logic        w_t7_fall;
    logic        w_ca1;

    state_t      r_state;
    op_t         r_op;
    logic        r_ca1;
    logic [7:0]  r_wdata;
    logic        r_cap;
    logic        r_rd_done;
    logic [15:0] r_addr_n;
    logic [3:0]  r_z2;
    logic [3:0]  r_z3;
    logic [3:0]  r_data;
    logic [3:0]  r_en_ram;
    logic [3:0]  r_en_10w;
    logic [7:0]  r_rdata;
    logic        r_rsp;

    tn_edge u_tn_edge (
        .i_clk     (ram_clk),
        .i_rst_n   (initn),
        .i_tn      (tn),
        .o_t4_rise (w_t4_rise),
        .o_t5_fall (w_t5_fall),
        .o_t7_fall (w_t7_fall)
    );

    // Page loads always go through the A1/A2 path.
    assign w_ca1 = req_ca1 | (req_op == OP_PAGE);

    always_ff @(posedge ram_clk or negedge initn) begin
        if (!initn) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_READ;
            r_ca1     <= 1'b0;
            r_wdata   <= 8'h00;
            r_cap     <= 1'b0;
            r_rd_done <= 1'b0;
            r_addr_n  <= 16'hFFFF;
            r_z2      <= 4'h0;
            r_z3      <= 4'h0;
            r_data    <= 4'h0;
            r_en_ram  <= IDLE_OP;
            r_en_10w  <= 4'hF;
            r_rdata   <= 8'h00;
            r_rsp     <= 1'b0;
        end else begin
            r_rsp <= 1'b0;
            if (r_cap) begin
                r_rdata <= {Y, X};
                r_rsp   <= 1'b1;
                r_cap   <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_t5_fall && req_valid && (req_op != OP_RSVD)) begin
                        r_op      <= op_t'(req_op);
                        r_ca1     <= w_ca1;
                        r_wdata   <= req_wdata;
                        r_rd_done <= 1'b0;
                        r_addr_n  <= addr_map(req_addr, w_ca1);
                        r_z2      <= req_addr[7:4];
                        r_z3      <= req_addr[3:0];
                        r_state   <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (w_t7_fall) begin
                        r_en_ram <= r_ca1 ? EN_CA1 : EN_CA3;
                        r_data   <= r_wdata[7:4];
                        r_state  <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if ((r_op == OP_READ) && w_t4_rise && !r_rd_done) begin
                        r_cap     <= 1'b1;
                        r_rd_done <= 1'b1;
                    end
                    if (w_t7_fall) begin
                        if (r_op == OP_READ) begin
                            r_en_ram <= IDLE_OP;
                            r_state  <= ST_IDLE;
                        end else if (r_op == OP_WRITE) begin
                            r_en_ram <= EN_ZPY;
                            r_state  <= ST_WR_HI;
                        end else begin
                            r_en_ram <= EN_PAGE;
                            r_en_10w <= PAGE_10W;
                            r_state  <= ST_PAGE;
                        end
                    end
                end
                ST_WR_HI: begin
                    if (w_t7_fall) begin
                        r_data   <= r_wdata[3:0];
                        r_en_ram <= EN_ZPX;
                        r_state  <= ST_WR_LO;
                    end
                end
                ST_WR_LO: begin
                    if (w_t7_fall) begin
                        r_en_ram <= IDLE_OP;
                        r_rsp    <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_PAGE: begin
                    if (w_t7_fall) begin
                        r_en_ram <= IDLE_OP;
                        r_en_10w <= 4'hF;
                        r_rsp    <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp;
    assign rsp_rdata = r_rdata;
    assign Addr_n    = r_addr_n;
    assign Z2        = r_z2;
    assign Z3        = r_z3;
    assign Data      = r_data;
    assign en_ram    = r_en_ram;
    assign en_10w    = r_en_10w;

endmodule

// File: tb/tb_ram_byte_master.sv
// Directed bench for ram_byte_master: free-running tn phase generator, a one-cell
// RAM model on X/Y, a vector table plus hand sequences for reset and back-to-back.
module tb_ram_byte_master;

    logic        clk = 1'b0;
    logic        initn;
    logic [10:1] tn;
    logic        req_valid, req_ready, req_ca1, rsp_valid;
    logic [1:0]  req_op;
    logic [15:0] req_addr, Addr_n;
    logic [7:0]  req_wdata, rsp_rdata;
    logic [3:0]  Z2, Z3, Data, en_ram, en_10w, X, Y;

    int n_checks = 0;
    int n_errors = 0;
    int mc = 0;
    int phase = 0;
    int n_rsp = 0;
    int rsp_mc = 0;
    int n_10w = 0;
    int n_pg = 0;
    logic [7:0] rsp_data = 8'h00;
    logic [3:0] en_log[$];
    logic [3:0] prev_en = 4'hF;
    logic [3:0] my = 4'h0;
    logic [3:0] mx = 4'h0;
    logic       use_pre = 1'b0;
    logic [7:0] pre_val = 8'h00;

    assign {Y, X} = use_pre ? pre_val : {my, mx};

    always #5 clk = ~clk;

    ram_byte_master dut (
        .ram_clk   (clk),
        .initn     (initn),
        .tn        (tn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_ca1   (req_ca1),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .Addr_n    (Addr_n),
        .Z2        (Z2),
        .Z3        (Z3),
        .Data      (Data),
        .en_ram    (en_ram),
        .en_10w    (en_10w),
        .X         (X),
        .Y         (Y)
    );

    // Machine cycle = 10 phases of 2 clocks, phase k pulls tn[k] low.
    initial begin
        tn = '1;
        forever begin
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (k == 1) mc = mc + 1;
                phase = k;
                tn = ~(10'd1 << (k - 1));
                @(negedge clk);
            end
        end
    end

    // Monitor and RAM model: ZPY stores Data as the Y nibble, ZPX as X.
    always begin
        @(posedge clk);
        #1;
        if (rsp_valid === 1'b1) begin
            n_rsp    = n_rsp + 1;
            rsp_mc   = mc;
            rsp_data = rsp_rdata;
        end
        if (en_ram !== prev_en) begin
            en_log.push_back(en_ram);
            prev_en = en_ram;
        end
        if (en_10w === 4'b0111) n_10w = n_10w + 1;
        if (en_ram === 4'b0000) n_pg = n_pg + 1;
        if (en_ram === 4'b0100) my = Data;
        if (en_ram === 4'b1000) mx = Data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input logic lvl, input int budget, input string name);
        int n = 0;
        while (req_ready !== lvl && n < budget) begin
            tick();
            n++;
        end
        chk(name, {31'd0, req_ready}, {31'd0, lvl});
    endtask

    typedef struct {
        logic [1:0]  op;
        logic        ca1;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        pre;
        logic [7:0]  pre_val;
        logic [15:0] e_addr_n;
        logic [3:0]  e_z2;
        logic [3:0]  e_z3;
        logic [7:0]  e_rdata;
        int          e_span;
        int          e_nen;
        logic [15:0] e_seq;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input int i);
        vec_t v;
        int acc_mc, s_rsp, s_en, s_10w, s_pg, n;
        logic [15:0] seq;
        v = vecs[i];
        use_pre = v.pre;
        pre_val = v.pre_val;
        s_rsp = n_rsp;
        s_en  = en_log.size();
        s_10w = n_10w;
        s_pg  = n_pg;
        req_op = v.op; req_ca1 = v.ca1; req_addr = v.addr; req_wdata = v.wdata;
        req_valid = 1'b1;
        wait_ready(1'b0, 40, $sformatf("v%0d accept", i));
        acc_mc = mc;
        // Request lines wander while busy; none of it may leak into the operation.
        req_op    = (v.op == 2'b00) ? 2'b01 : 2'b00;
        req_ca1   = ~v.ca1;
        req_addr  = ~v.addr;
        req_wdata = ~v.wdata;
        n = 0;
        while (n_rsp == s_rsp && n < 120) begin
            tick();
            n++;
        end
        req_valid = 1'b0;
        chk($sformatf("v%0d span", i), rsp_mc - acc_mc + 1, v.e_span);
        chk($sformatf("v%0d Addr_n", i), {16'd0, Addr_n}, {16'd0, v.e_addr_n});
        chk($sformatf("v%0d Z2", i), {28'd0, Z2}, {28'd0, v.e_z2});
        chk($sformatf("v%0d Z3", i), {28'd0, Z3}, {28'd0, v.e_z3});
        wait_ready(1'b1, 40, $sformatf("v%0d idle", i));
        chk($sformatf("v%0d rsp count", i), n_rsp - s_rsp, 1);
        seq = '0;
        for (int j = s_en; j < en_log.size(); j++) seq = {seq[11:0], en_log[j]};
        chk($sformatf("v%0d en_ram count", i), en_log.size() - s_en, v.e_nen);
        chk($sformatf("v%0d en_ram seq", i), {16'd0, seq}, {16'd0, v.e_seq});
        chk($sformatf("v%0d en_10w clocks", i), n_10w - s_10w, (v.op == 2'b10) ? 20 : 0);
        if (v.op == 2'b10) chk($sformatf("v%0d page clocks", i), n_pg - s_pg, 20);
        if (v.op == 2'b00) chk($sformatf("v%0d rdata", i), {24'd0, rsp_data}, {24'd0, v.e_rdata});
        if (v.op == 2'b01) chk($sformatf("v%0d ram cell", i), {24'd0, my, mx}, {24'd0, v.wdata});
    endtask

    initial begin
        int n, rel_mc, s_rsp, s_en, a1, a2;
        //          op     ca1   addr      wd     pre   pv     Addr_n    Z2    Z3    rdata  span nen seq
        vecs[0] = '{2'b01, 1'b0, 16'h0001, 8'h09, 1'b0, 8'h00, 16'hFFFF, 4'h0, 4'h1, 8'h00, 4, 4, 16'hA48F};
        vecs[1] = '{2'b00, 1'b0, 16'h0001, 8'h00, 1'b0, 8'h00, 16'hFFFF, 4'h0, 4'h1, 8'h09, 2, 2, 16'h00AF};
        vecs[2] = '{2'b00, 1'b1, 16'hA5C3, 8'h00, 1'b1, 8'h5A, 16'hFFA5, 4'hC, 4'h3, 8'h5A, 2, 2, 16'h006F};
        vecs[3] = '{2'b01, 1'b1, 16'h1234, 8'hC3, 1'b0, 8'h00, 16'hFFDE, 4'h3, 4'h4, 8'h00, 4, 4, 16'h648F};
        vecs[4] = '{2'b00, 1'b0, 16'h7E10, 8'h00, 1'b0, 8'h00, 16'h18FF, 4'h1, 4'h0, 8'hC3, 2, 2, 16'h00AF};
        vecs[5] = '{2'b10, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 16'hFFFF, 4'h0, 4'h0, 8'h00, 3, 3, 16'h060F};
        vecs[6] = '{2'b10, 1'b0, 16'hBEEF, 8'h00, 1'b0, 8'h00, 16'hFF14, 4'hE, 4'hF, 8'h00, 3, 3, 16'h060F};
        vecs[7] = '{2'b01, 1'b0, 16'hFFFF, 8'h00, 1'b0, 8'h00, 16'h00FF, 4'hF, 4'hF, 8'h00, 4, 4, 16'hA48F};
        vecs[8] = '{2'b00, 1'b1, 16'h0000, 8'h00, 1'b1, 8'hA5, 16'hFFFF, 4'h0, 4'h0, 8'hA5, 2, 2, 16'h006F};

        initn = 1'b1;
        req_valid = 1'b0; req_op = 2'b00; req_ca1 = 1'b1; req_addr = 16'h0000; req_wdata = 8'h00;
        #3 initn = 1'b0;
        #1;
        chk("reset en_ram", {28'd0, en_ram}, 32'hF);
        chk("reset en_10w", {28'd0, en_10w}, 32'hF);
        chk("reset Addr_n", {16'd0, Addr_n}, 32'hFFFF);
        chk("reset Z2/Z3/Data", {20'd0, Z2, Z3, Data}, 32'h0);
        chk("reset rsp", {23'd0, rsp_valid, rsp_rdata}, 32'h0);
        chk("reset ready", {31'd0, req_ready}, 32'h1);

        // Release reset while tn5 is already low: that level is not a fall.
        req_valid = 1'b1;
        repeat (3) tick();
        n = 0;
        while (phase == 5 && n < 40) begin tick(); n++; end
        while (phase != 5 && n < 80) begin tick(); n++; end
        initn = 1'b1;
        rel_mc = mc;
        repeat (8) tick();
        chk("no accept before tn5 fall", {31'd0, req_ready}, 32'h1);
        wait_ready(1'b0, 40, "first accept");
        chk("first accept cycle", mc - rel_mc, 1);
        req_valid = 1'b0;
        wait_ready(1'b1, 60, "first idle");

        // Reserved op is ignored.
        s_en = en_log.size();
        req_op = 2'b11; req_addr = 16'h1357; req_valid = 1'b1;
        repeat (25) tick();
        chk("op11 ready", {31'd0, req_ready}, 32'h1);
        chk("op11 en_ram", {28'd0, en_ram}, 32'hF);
        chk("op11 en_ram changes", en_log.size() - s_en, 0);
        req_valid = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(i);

        // Back-to-back reads with req_valid held high.
        s_rsp = n_rsp;
        use_pre = 1'b1; pre_val = 8'h3C;
        req_op = 2'b00; req_ca1 = 1'b1; req_addr = 16'h0102; req_valid = 1'b1;
        wait_ready(1'b0, 40, "b2b accept 1");
        a1 = mc;
        wait_ready(1'b1, 60, "b2b idle 1");
        req_addr = 16'h0304;
        wait_ready(1'b0, 40, "b2b accept 2");
        a2 = mc;
        req_valid = 1'b0;
        wait_ready(1'b1, 60, "b2b idle 2");
        chk("b2b accept gap", a2 - a1, 2);
        chk("b2b rsp count", n_rsp - s_rsp, 2);
        chk("b2b Addr_n", {16'd0, Addr_n}, 32'hFFCF);
        chk("b2b rdata", {24'd0, rsp_data}, 32'h3C);

        // Reset in the middle of a write (WR_HI).
        s_rsp = n_rsp;
        use_pre = 1'b0;
        req_op = 2'b01; req_ca1 = 1'b1; req_addr = 16'h4321; req_wdata = 8'h7E; req_valid = 1'b1;
        wait_ready(1'b0, 40, "abort accept");
        req_valid = 1'b0;
        n = 0;
        while (en_ram !== 4'b0100 && n < 80) begin tick(); n++; end
        chk("abort reached WR_HI", {28'd0, en_ram}, 32'h4);
        repeat (5) tick();
        initn = 1'b0;
        #1;
        chk("abort en_ram", {28'd0, en_ram}, 32'hF);
        chk("abort en_10w", {28'd0, en_10w}, 32'hF);
        chk("abort Addr_n", {16'd0, Addr_n}, 32'hFFFF);
        chk("abort Z2/Z3/Data", {20'd0, Z2, Z3, Data}, 32'h0);
        chk("abort rsp", {23'd0, rsp_valid, rsp_rdata}, 32'h0);
        chk("abort ready", {31'd0, req_ready}, 32'h1);
        repeat (3) tick();
        initn = 1'b1;
        repeat (80) tick();
        chk("abort no rsp", n_rsp - s_rsp, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_byte_master.md
RAM_BYTE_MASTER -- requirements
Module: ram_byte_master

Interface
REQ-001 SHALL have parameter IDLE_OP, default 4'b1111, the En[20:17] code meaning "no RAM operation".
REQ-002 SHALL have parameter PAGE_10W, default 4'b0111, the En[28:25] code that asserts 10w1.
REQ-003 ram_clk  in  1  system clock; all state updates on rising edge.
REQ-004 initn  in  1  reset, asynchronous, active-low.
REQ-005 tn  in  10 [10:1]  machine-cycle phase strobes, active-low, synchronous to ram_clk.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_op  in  2  request type: 00 read, 01 write, 10 page-register load, 11 reserved.
REQ-009 req_ca1  in  1  address mode: 1 CA1 (A1/A2 path), 0 CA3 (A3/A4 path).
REQ-010 req_addr  in  16  virtual byte address.
REQ-011 req_wdata  in  8  write byte.
REQ-012 rsp_valid  out  1  one-clock completion pulse.
REQ-013 rsp_rdata  out  8  read byte {Y,X}.
REQ-014 Addr_n  out  16  pseudo address bus {A4n,A3n,A2n,A1n}.
REQ-015 Z2, Z3  out  4 each  address nibbles.
REQ-016 Data  out  4  write nibble (sigma bus).
REQ-017 en_ram  out  4  En[20:17] operation code.
REQ-018 en_10w  out  4  En[28:25] code.
REQ-019 X, Y  in  4 each  RAM read nibbles.

Function
REQ-020 SHALL edge-detect tn[5] fall, tn[7] fall and tn[4] rise with one registered copy of tn; every state step below occurs on the clock of detection.
REQ-021 States SHALL be IDLE, ARM, ADDR, WR_HI, WR_LO, PAGE; req_ready = 1 only in IDLE.
REQ-022 IDLE: on tn[5] fall with req_valid=1 and req_op!=11, latch the request, drive the address per REQ-023, go to ARM; req_op=11 is ignored and the block stays in IDLE.
REQ-023 CA1: Addr_n[3:0]=~addr[15:12], Addr_n[7:4]=~addr[11:8]; CA3: Addr_n[11:8]=~addr[15:12], Addr_n[15:12]=~addr[11:8]; all other Addr_n nibbles = 4'hF; Z2=addr[7:4]; Z3=addr[3:0]; page load always uses CA1.
REQ-024 ARM, on tn[7] fall: en_ram = 0110 (CA1) or 1010 (CA3); Data = wdata[7:4]; go to ADDR.
REQ-025 ADDR, read: on the first tn[4] rise, the following clock SHALL capture rsp_rdata={Y,X} and pulse rsp_valid; on tn[7] fall, en_ram=IDLE_OP and go to IDLE.
REQ-026 ADDR, write: on tn[7] fall, en_ram=0100 (ZPY), go to WR_HI.
REQ-027 WR_HI, on tn[7] fall: Data=wdata[3:0], en_ram=1000 (ZPX), go to WR_LO.
REQ-028 WR_LO, on tn[7] fall: en_ram=IDLE_OP, pulse rsp_valid, go to IDLE.
REQ-029 ADDR, page load: on tn[7] fall, en_ram=0000, en_10w=PAGE_10W, go to PAGE; PAGE on tn[7] fall: en_ram=IDLE_OP, en_10w=4'hF, pulse rsp_valid, go to IDLE.
REQ-030 Latency: read = 2 machine cycles; write = 4; page load = 3, each measured from acceptance.
REQ-031 Address outputs SHALL hold their value from acceptance until the next acceptance.
REQ-032 Changes on req_* outside IDLE SHALL have no effect.
REQ-033 Back-to-back requests SHALL be legal: acceptance may occur on the tn[5] fall of the cycle following a return to IDLE.

Reset
REQ-034 initn low SHALL immediately force: state IDLE, en_ram=IDLE_OP, en_10w=4'hF, Addr_n=16'hFFFF, Z2=Z3=Data=0, rsp_rdata=0, rsp_valid=0.
REQ-035 Reset mid-operation SHALL abort the operation with no rsp_valid pulse; a partial write is permitted.
REQ-036 After initn rises, no acceptance SHALL occur before the first detected tn[5] fall.

Structure
REQ-037 The shared package SHALL hold the operation codes (CC 1110, CA1 0110, CA3 1010, ZPCY 0010, ZPCX 1100, ZPY 0100, ZPX 1000, PAGE 0000, NOP 1111), the req_op encoding and the state enumeration.
REQ-038 The block SHALL contain one sub-module, tn_edge, implementing the phase-strobe edge detector.

Verification
REQ-039 Write 0x0001 with wdata 0x09 in CA3 mode, then read it back -> en_ram sequence 1010, 0100, 1000, 1111; rsp_rdata=0x09.
REQ-040 Read 0xA5C3 in CA1 mode -> Addr_n=16'hFFA5 (A1n=0x5, A2n=0xA); Z2=0xC; Z3=0x3.
REQ-041 Page load of 0x0000 -> en_ram=0000 and en_10w=0111 for exactly one machine cycle; rsp_valid pulse 3 cycles after acceptance.
REQ-042 Pull initn low during WR_HI -> outputs reach reset values in the same clock; no rsp_valid pulse.
REQ-043 Two reads issued back-to-back -> second accepted on the next tn[5] fall after IDLE; two rsp_valid pulses.
REQ-044 req_op=11 -> stays in IDLE; en_ram stays 1111.
